// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU-control decoder with multi-cycle sequencing.
// Decodes ALUOp/Funct7/Funct3 into an OP_W-bit operation code. When the
// optional muldiv unit is enabled, MUL*/DIV*/REM* start a latency counter
// and hold stall high until the result is ready.
// Optional feature macro: ALU_CTRL_SEQ_MULDIV_EN (M extension decode plus
// the MUL/DIV/DONE sequencing states). Undefined: single-cycle only.
module alu_ctrl_seq #(
    parameter int OP_W       = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    output logic [OP_W-1:0] Operation,
    output logic            op_valid,
    output logic            stall,
    output logic            done,
    output logic            illegal
);

`ifdef ALU_CTRL_SEQ_MULDIV_EN
    localparam logic MULDIV_EN = 1'b1;
`else
    localparam logic MULDIV_EN = 1'b0;
`endif

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              illegal_q, illegal_d;
    logic              op_valid_q, op_valid_d;
    logic              stall_q, stall_d;
    logic              done_q, done_d;

    logic [4:0]        dec_op_s;
    logic              dec_ill_s;
    logic              dec_mul_s;
    logic              dec_div_s;
    logic              ready_s;
    logic              accept_s;

    // Instruction decode: funct fields to operation code, illegal and unit class.
    always_comb begin
        dec_op_s  = 5'b00010;
        dec_ill_s = 1'b0;
        dec_mul_s = 1'b0;
        dec_div_s = 1'b0;
        case (ALUOp)
            2'b00: dec_op_s = 5'b00010;
            2'b01: dec_op_s = 5'b00110;
            2'b10: begin
                case (Funct7)
                    7'b0000000: begin
                        case (Funct3)
                            3'b000:  dec_op_s = 5'b00010;
                            3'b001:  dec_op_s = 5'b00011;
                            3'b010:  dec_op_s = 5'b00111;
                            3'b011:  dec_op_s = 5'b01000;
                            3'b100:  dec_op_s = 5'b01100;
                            3'b101:  dec_op_s = 5'b00100;
                            3'b110:  dec_op_s = 5'b00001;
                            3'b111:  dec_op_s = 5'b00000;
                            default: dec_ill_s = 1'b1;
                        endcase
                    end
                    7'b0100000: begin
                        case (Funct3)
                            3'b000:  dec_op_s = 5'b00110;
                            3'b101:  dec_op_s = 5'b00101;
                            default: dec_ill_s = 1'b1;
                        endcase
                    end
`ifdef ALU_CTRL_SEQ_MULDIV_EN
                    7'b0000001: begin
                        dec_op_s  = {2'b10, Funct3};
                        dec_mul_s = ~Funct3[2];
                        dec_div_s = Funct3[2];
                    end
`endif
                    default: dec_ill_s = 1'b1;
                endcase
            end
            2'b11: begin
                case (Funct3)
                    3'b000:  dec_op_s = 5'b00010;
                    3'b001: begin
                        if (Funct7 == 7'b0000000) begin
                            dec_op_s = 5'b00011;
                        end else begin
                            dec_ill_s = 1'b1;
                        end
                    end
                    3'b010:  dec_op_s = 5'b00111;
                    3'b011:  dec_op_s = 5'b01000;
                    3'b100:  dec_op_s = 5'b01100;
                    3'b101: begin
                        if (Funct7 == 7'b0000000) begin
                            dec_op_s = 5'b00100;
                        end else if (Funct7 == 7'b0100000) begin
                            dec_op_s = 5'b00101;
                        end else begin
                            dec_ill_s = 1'b1;
                        end
                    end
                    3'b110:  dec_op_s = 5'b00001;
                    3'b111:  dec_op_s = 5'b00000;
                    default: dec_ill_s = 1'b1;
                endcase
            end
            default: dec_ill_s = 1'b1;
        endcase
        // An illegal encoding always falls back to ADD and never starts muldiv.
        if (dec_ill_s) begin
            dec_op_s  = 5'b00010;
            dec_mul_s = 1'b0;
            dec_div_s = 1'b0;
        end else begin
            dec_op_s  = dec_op_s;
        end
    end

    assign ready_s  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept_s = in_valid & ready_s;

    // Next-state, counter and output-register computation.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        illegal_d  = illegal_q;
        op_valid_d = 1'b0;
        stall_d    = 1'b0;
        done_d     = 1'b0;
        if (flush) begin
            // Abort: return to idle, drop all status, keep the last op code.
            state_d   = ST_IDLE;
            count_d   = '0;
            illegal_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        op_d       = OP_W'(dec_op_s);
                        illegal_d  = dec_ill_s;
                        op_valid_d = 1'b1;
                        if (MULDIV_EN && dec_mul_s) begin
                            state_d = ST_MUL;
                            count_d = CNT_W'(MUL_CYCLES - 2);
                            stall_d = 1'b1;
                        end else if (MULDIV_EN && dec_div_s) begin
                            state_d = ST_DIV;
                            count_d = CNT_W'(DIV_CYCLES - 2);
                            stall_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    op_valid_d = 1'b1;
                    if (count_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                        stall_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            op_q       <= '0;
            illegal_q  <= 1'b0;
            op_valid_q <= 1'b0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            illegal_q  <= illegal_d;
            op_valid_q <= op_valid_d;
            stall_q    <= stall_d;
            done_q     <= done_d;
        end
    end

    // in_ready is gated by rst_n so it is low during the reset cycle itself.
    assign in_ready  = rst_n & ready_s;
    assign Operation = op_q;
    assign op_valid  = op_valid_q;
    assign illegal   = illegal_q;
    assign stall     = stall_q & MULDIV_EN;
    assign done      = done_q & MULDIV_EN;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Testbench for alu_ctrl_seq: table-driven decode vectors plus hand-written
// sequences for reset, flush and (when enabled) muldiv latency.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] ALUOp;
    logic [6:0] Funct7;
    logic [2:0] Funct3;
    logic [4:0] Operation;
    logic       op_valid;
    logic       stall;
    logic       done;
    logic       illegal;

    int checks   = 0;
    int failures = 0;

    alu_ctrl_seq #(.OP_W(5), .MUL_CYCLES(4), .DIV_CYCLES(33)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .Funct7    (Funct7),
        .Funct3    (Funct3),
        .Operation (Operation),
        .op_valid  (op_valid),
        .stall     (stall),
        .done      (done),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] aluop;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] op;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] a, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [4:0] op, input logic ill);
        vec_t v;
        v.aluop = a; v.f7 = f7; v.f3 = f3; v.op = op; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [6:0] f7, input logic [2:0] f3);
        in_valid = v; ALUOp = a; Funct7 = f7; Funct3 = f3;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int seen_done;
        // Decode table
        add(2'b00, 7'b1010101, 3'b111, 5'b00010, 1'b0);
        add(2'b01, 7'b1111111, 3'b011, 5'b00110, 1'b0);
        add(2'b10, 7'b0000000, 3'b000, 5'b00010, 1'b0);
        add(2'b10, 7'b0000000, 3'b001, 5'b00011, 1'b0);
        add(2'b10, 7'b0000000, 3'b010, 5'b00111, 1'b0);
        add(2'b10, 7'b0000000, 3'b011, 5'b01000, 1'b0);
        add(2'b10, 7'b0000000, 3'b100, 5'b01100, 1'b0);
        add(2'b10, 7'b0000000, 3'b101, 5'b00100, 1'b0);
        add(2'b10, 7'b0000000, 3'b110, 5'b00001, 1'b0);
        add(2'b10, 7'b0000000, 3'b111, 5'b00000, 1'b0);
        add(2'b10, 7'b0100000, 3'b000, 5'b00110, 1'b0);
        add(2'b10, 7'b0100000, 3'b101, 5'b00101, 1'b0);
        add(2'b11, 7'b1111111, 3'b000, 5'b00010, 1'b0);
        add(2'b11, 7'b0000000, 3'b001, 5'b00011, 1'b0);
        add(2'b11, 7'b1100110, 3'b010, 5'b00111, 1'b0);
        add(2'b11, 7'b0000111, 3'b011, 5'b01000, 1'b0);
        add(2'b11, 7'b0101010, 3'b100, 5'b01100, 1'b0);
        add(2'b11, 7'b0000000, 3'b101, 5'b00100, 1'b0);
        add(2'b11, 7'b0100000, 3'b101, 5'b00101, 1'b0);
        add(2'b11, 7'b1000001, 3'b110, 5'b00001, 1'b0);
        add(2'b11, 7'b0010000, 3'b111, 5'b00000, 1'b0);
        add(2'b10, 7'b1111111, 3'b000, 5'b00010, 1'b1);
        add(2'b10, 7'b0100000, 3'b001, 5'b00010, 1'b1);
        add(2'b11, 7'b0100000, 3'b001, 5'b00010, 1'b1);
        add(2'b11, 7'b0000001, 3'b101, 5'b00010, 1'b1);
        add(2'b10, 7'b0000000, 3'b100, 5'b01100, 1'b0);
`ifndef ALU_CTRL_SEQ_MULDIV_EN
        add(2'b10, 7'b0000001, 3'b000, 5'b00010, 1'b1);
        add(2'b10, 7'b0000001, 3'b101, 5'b00010, 1'b1);
`endif

        // Reset with in_valid high
        rst_n = 1'b0; flush = 1'b0;
        drive(1'b1, 2'b10, 7'b0100000, 3'b000);
        step();
        step();
        chk("rst_operation", 32'(Operation), 32'h0);
        chk("rst_op_valid", 32'(op_valid), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'h1);

        // Back-to-back decode sweep
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].aluop, vecs[i].f7, vecs[i].f3);
            step();
            chk($sformatf("vec%0d_op", i), 32'(Operation), 32'(vecs[i].op));
            chk($sformatf("vec%0d_ill", i), 32'(illegal), 32'(vecs[i].ill));
            chk($sformatf("vec%0d_valid", i), 32'(op_valid), 32'h1);
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'h0);
        end
        in_valid = 1'b0;
        step();
        chk("pulse_end_valid", 32'(op_valid), 32'h0);
        chk("hold_op", 32'(Operation), 32'(vecs[vecs.size()-1].op));

        // Flush beats a concurrent accept; Operation held, illegal cleared
        drive(1'b1, 2'b10, 7'b1111111, 3'b000);
        step();
        chk("ill_set", 32'(illegal), 32'h1);
        flush = 1'b1;
        drive(1'b1, 2'b10, 7'b0000000, 3'b100);
        step();
        chk("flush_valid", 32'(op_valid), 32'h0);
        chk("flush_ill", 32'(illegal), 32'h0);
        chk("flush_op_held", 32'(Operation), 32'h02);
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        chk("flush_no_accept", 32'(Operation), 32'h02);
        chk("flush_after_valid", 32'(op_valid), 32'h0);

`ifdef ALU_CTRL_SEQ_MULDIV_EN
        // MUL latency, busy-ignore and no-bubble accept in DONE
        drive(1'b1, 2'b10, 7'b0000001, 3'b000);
        step();                                  // T+1
        drive(1'b1, 2'b10, 7'b0000000, 3'b100);  // XOR while busy
        chk("mul_t1_op", 32'(Operation), 32'h10);
        chk("mul_t1_stall", 32'(stall), 32'h1);
        chk("mul_t1_ready", 32'(in_ready), 32'h0);
        chk("mul_t1_valid", 32'(op_valid), 32'h1);
        chk("mul_t1_done", 32'(done), 32'h0);
        step();                                  // T+2
        chk("mul_t2_stall", 32'(stall), 32'h1);
        chk("mul_t2_op", 32'(Operation), 32'h10);
        step();                                  // T+3
        chk("mul_t3_stall", 32'(stall), 32'h1);
        chk("mul_t3_ready", 32'(in_ready), 32'h0);
        drive(1'b1, 2'b00, 7'b0000000, 3'b000);  // ADD
        step();                                  // T+4
        chk("mul_t4_done", 32'(done), 32'h1);
        chk("mul_t4_stall", 32'(stall), 32'h0);
        chk("mul_t4_ready", 32'(in_ready), 32'h1);
        chk("mul_t4_op", 32'(Operation), 32'h10);
        step();                                  // T+5
        in_valid = 1'b0;
        chk("mul_t5_op", 32'(Operation), 32'h02);
        chk("mul_t5_valid", 32'(op_valid), 32'h1);
        chk("mul_t5_stall", 32'(stall), 32'h0);
        chk("mul_t5_done", 32'(done), 32'h0);
        step();

        // DIVU then flush at T+10
        drive(1'b1, 2'b10, 7'b0000001, 3'b101);
        step();
        drive(1'b1, 2'b10, 7'b0000000, 3'b100);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("div_stall_t%0d", k), 32'(stall), 32'h1);
            chk($sformatf("div_op_t%0d", k), 32'(Operation), 32'h15);
            if (k < 10) step();
        end
        flush = 1'b1;
        in_valid = 1'b0;
        step();                                  // T+11
        flush = 1'b0;
        chk("divf_stall", 32'(stall), 32'h0);
        chk("divf_valid", 32'(op_valid), 32'h0);
        chk("divf_ready", 32'(in_ready), 32'h1);
        chk("divf_op_held", 32'(Operation), 32'h15);
        seen_done = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) seen_done++;
            step();
        end
        chk("divf_no_done", 32'(seen_done), 32'h0);

        // Full REM latency, then idle after DONE
        drive(1'b1, 2'b10, 7'b0000001, 3'b110);
        step();
        in_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 60) begin
            step();
            cyc++;
        end
        chk("rem_latency", 32'(cyc), 32'd33);
        chk("rem_op", 32'(Operation), 32'h16);
        step();
        chk("rem_after_valid", 32'(op_valid), 32'h0);
        chk("rem_after_done", 32'(done), 32'h0);
        chk("rem_after_stall", 32'(stall), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
